// File: rtl/operand_skew_feeder_if.sv
// Purpose : bundles the command, operand-memory and array-feed signals of the skew feeder.
// Latency : n/a (wiring only).
// Backpressure: none; the feeder runs on a fixed cadence and the array must accept every beat.
// Ports   : start/base_col/num_cols (command), mem_en/mem_addr/mem_data (operand memory),
//           feed_data/feed_valid (array side), busy/done (status).
interface operand_skew_feeder_if;
   logic        start;
   logic [7:0]  base_col;
   logic [8:0]  num_cols;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [15:0] mem_data;
   logic [63:0] feed_data;
   logic        feed_valid;
   logic        busy;
   logic        done;

   // feeder side
   modport master (
      input  start, base_col, num_cols, mem_data,
      output mem_en, mem_addr, feed_data, feed_valid, busy, done
   );

   // requester / memory / array side
   modport slave (
      output start, base_col, num_cols, mem_data,
      input  mem_en, mem_addr, feed_data, feed_valid, busy, done
   );
endinterface

// File: rtl/operand_skew_feeder.sv
// Purpose : reads a K-column operand slice row by row and feeds it diagonally skewed to a 4-row array.
// Latency : first read one cycle after start, beat b at cycle 4b+5, done at cycle 4K+14.
// Backpressure: none; start is ignored while busy, beats are strobed on a fixed 4-cycle cadence.
// Ports   : clk, rst (async, active-high); bus (master modport) carries command, memory and feed signals.
module operand_skew_feeder #(
   parameter int ROWS       = 4,    // datapath below is laid out for 4 rows
   parameter int ROW_STRIDE = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   operand_skew_feeder_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, FLUSH, FINISH} state_t;

   state_t      state;
   state_t      state_nxt;

   logic [7:0]  base_q;
   logic [8:0]  k_q;
   logic [10:0] cyc;          // cycle number within the pass, 1 in the first FETCH cycle
   logic [10:0] fetch_end;
   logic [10:0] flush_end;
   logic        accept;

   logic        mem_en_c;
   logic        busy_c;
   logic        done_c;

   logic [9:0]  rd_idx;       // read sequence number: column in [9:2], row in [1:0]
   logic [7:0]  rd_col;
   logic        rd_vld;
   logic [1:0]  rd_row;

   logic [15:0] colbuf [ROWS];
   logic [15:0] dly1;
   logic [15:0] dly2;
   logic [15:0] dly3a;
   logic [15:0] dly3b;
   logic [63:0] feed_q;
   logic        feed_vld_q;

   logic        beat_edge;
   logic [8:0]  beat;
   logic        cur_ok;
   logic        prev_ok;

   assign fetch_end = {k_q, 2'b00};
   assign flush_end = fetch_end + 11'd13;
   assign accept    = bus.start && ((state == IDLE) || (state == FINISH));

   // The column field is 8 bits, so base+k wraps inside the row and never
   // carries into the row part of the address.
   assign rd_idx = cyc[9:0] - 10'd1;
   assign rd_col = base_q + rd_idx[9:2];

   // Beat b is loaded at the end of cycle 4b+4 so it is visible in cycle 4b+5.
   assign beat_edge = busy_c && (cyc[1:0] == 2'b00);
   assign beat      = cyc[10:2] - 9'd1;

   // At the beat edge for beat b, rows 0/1 of the column buffer already hold
   // column b while rows 2/3 still hold column b-1 (row 2 is overwritten on
   // this very edge, row 3 one cycle later). Each is masked by whether the
   // column it holds lies inside 0..K-1, so the skew ramps fill with zeros.
   assign cur_ok  = {1'b0, beat} < {1'b0, k_q};
   assign prev_ok = (beat != 9'd0) && (beat <= k_q);

   always_comb begin
      state_nxt = state;
      mem_en_c  = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = (bus.num_cols != 9'd0) ? FETCH : FINISH;
         end
         FETCH: begin
            mem_en_c = 1'b1;
            busy_c   = 1'b1;
            if (cyc == fetch_end) state_nxt = FLUSH;
         end
         FLUSH: begin
            busy_c = 1'b1;
            if (cyc == flush_end) state_nxt = FINISH;
         end
         FINISH: begin
            done_c = 1'b1;
            if (bus.start) state_nxt = (bus.num_cols != 9'd0) ? FETCH : FINISH;
            else           state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q     <= '0;
         k_q        <= '0;
         cyc        <= '0;
         rd_vld     <= 1'b0;
         rd_row     <= '0;
         for (int i = 0; i < ROWS; i++) colbuf[i] <= '0;
         dly1       <= '0;
         dly2       <= '0;
         dly3a      <= '0;
         dly3b      <= '0;
         feed_q     <= '0;
         feed_vld_q <= 1'b0;
      end else begin
         rd_vld     <= mem_en_c;
         rd_row     <= rd_idx[1:0];
         feed_vld_q <= 1'b0;
         if (accept) begin
            // New pass: parameters are frozen here and the skew pipeline is
            // emptied so the leading triangle of the first beats reads zero.
            base_q <= bus.base_col;
            k_q    <= bus.num_cols;
            cyc    <= 11'd1;
            for (int i = 0; i < ROWS; i++) colbuf[i] <= '0;
            dly1   <= '0;
            dly2   <= '0;
            dly3a  <= '0;
            dly3b  <= '0;
         end else begin
            if (busy_c) cyc <= cyc + 11'd1;
            if (rd_vld) colbuf[rd_row] <= bus.mem_data;
            if (beat_edge) begin
               feed_q     <= {dly3b, dly2, dly1, (cur_ok ? colbuf[0] : 16'd0)};
               feed_vld_q <= 1'b1;
               dly1       <= cur_ok  ? colbuf[1] : 16'd0;
               dly2       <= prev_ok ? colbuf[2] : 16'd0;
               dly3a      <= prev_ok ? colbuf[3] : 16'd0;
               dly3b      <= dly3a;
            end
         end
      end
   end

   assign bus.mem_en     = mem_en_c;
   assign bus.mem_addr   = 10'(ROW_STRIDE) * {8'd0, rd_idx[1:0]} + {2'b00, rd_col};
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.feed_data  = feed_q;
   assign bus.feed_valid = feed_vld_q;
endmodule

// File: tb/tb_operand_skew_feeder.sv
// Purpose : self-checking bench for operand_skew_feeder against a cycle-table reference model.
// Latency : n/a.
// Backpressure: n/a.
// Ports   : none; drives the slave side of operand_skew_feeder_if and models a 1-cycle operand memory.
module tb_operand_skew_feeder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          checks = 0;
   int          errors = 0;

   logic [15:0] mem [1024];
   logic        lat_en = 1'b0;
   logic [9:0]  lat_addr = '0;
   logic [63:0] model_feed = '0;
   logic [63:0] beats_got [$];
   logic [9:0]  addr_got [$];
   int          done_cyc;
   int          rk;
   int          rb;
   int          rb2;

   operand_skew_feeder_if bus ();

   operand_skew_feeder #(.ROWS(4), .ROW_STRIDE(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Operand memory: a request seen in cycle n is answered for the whole of cycle n+1;
   // otherwise the data lines carry junk.
   always @(negedge clk) begin
      bus.mem_data = lat_en ? mem[lat_addr] : 16'($urandom);
      lat_en       = bus.mem_en;
      lat_addr     = bus.mem_addr;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] elem(input int r, input int c, input int k, input int base);
      if (c < 0 || c >= k) return 16'd0;
      return mem[10'(256 * r + ((base + c) % 256))];
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
   endtask

   task automatic drive(input int k, input int base);
      bus.start    = 1'b1;
      bus.num_cols = 9'(k);
      bus.base_col = 8'(base);
   endtask

   task automatic idle(input int m);
      for (int i = 0; i < m; i++) begin
         @(negedge clk);
         chk("idle_mem_en", 64'(bus.mem_en), 64'd0);
         chk("idle_busy", 64'(bus.busy), 64'd0);
         chk("idle_valid", 64'(bus.feed_valid), 64'd0);
         chk("idle_done", 64'(bus.done), 64'd0);
      end
   endtask

   // Called at a negedge with start already driven; walks every cycle of the pass.
   task automatic run_pass(input int k, input int base, input int stray_at, input int rst_at,
                           input bit chain, input int nk, input int nbase);
      int          last;
      int          idx;
      int          b;
      bit          exp_en;
      bit          exp_busy;
      bit          exp_done;
      bit          exp_valid;
      logic [63:0] exp_feed;
      beats_got.delete();
      addr_got.delete();
      done_cyc = -1;
      last = (k == 0) ? 1 : 4 * k + 14;
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         if (n == 1) bus.start = 1'b0;
         if (n == stray_at) begin
            bus.start    = 1'b1;
            bus.num_cols = 9'd7;
            bus.base_col = 8'd99;
         end
         if (n == stray_at + 1) bus.start = 1'b0;
         exp_en    = (k > 0) && (n <= 4 * k);
         exp_busy  = (k > 0) && (n <= 4 * k + 13);
         exp_done  = (n == last);
         exp_valid = (k > 0) && (n >= 5) && ((n - 5) % 4 == 0) && ((n - 5) / 4 <= k + 2);
         chk("mem_en", 64'(bus.mem_en), 64'(exp_en));
         chk("busy", 64'(bus.busy), 64'(exp_busy));
         chk("done", 64'(bus.done), 64'(exp_done));
         chk("feed_valid", 64'(bus.feed_valid), 64'(exp_valid));
         if (exp_en) begin
            idx = n - 1;
            chk("mem_addr", 64'(bus.mem_addr), 64'(256 * (idx % 4) + (base + idx / 4) % 256));
            addr_got.push_back(bus.mem_addr);
         end
         if (exp_valid) begin
            b = (n - 5) / 4;
            exp_feed = '0;
            for (int r = 0; r < 4; r++) exp_feed[16*r +: 16] = elem(r, b - r, k, base);
            model_feed = exp_feed;
            beats_got.push_back(bus.feed_data);
         end
         chk("feed_data", bus.feed_data, model_feed);
         if (bus.done === 1'b1) done_cyc = n;
         if (n == rst_at) begin
            #1 rst = 1'b1;
            #1;
            chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_valid", 64'(bus.feed_valid), 64'd0);
            chk("rst_done", 64'(bus.done), 64'd0);
            chk("rst_feed", bus.feed_data, 64'd0);
            model_feed = '0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               chk("post_rst_done", 64'(bus.done), 64'd0);
               chk("post_rst_valid", 64'(bus.feed_valid), 64'd0);
               chk("post_rst_busy", 64'(bus.busy), 64'd0);
               chk("post_rst_mem_en", 64'(bus.mem_en), 64'd0);
               chk("post_rst_feed", bus.feed_data, 64'd0);
            end
            break;
         end
         if (n == last && chain) drive(nk, nbase);
      end
   endtask

   task automatic check_k4_directed();
      chk("k4_beat_count", 64'(beats_got.size()), 64'd7);
      if (beats_got.size() == 7) begin
         chk("k4_beat0", beats_got[0], {16'd0, 16'd0, 16'd0, 16'd1});
         chk("k4_beat3", beats_got[3], {16'd0, 16'd0, 16'd6, 16'd4});
         chk("k4_beat6", beats_got[6], {16'd13, 16'd0, 16'd0, 16'd0});
      end
      chk("k4_done_cycle", 64'(done_cyc), 64'd30);
   endtask

   initial begin
      int exp_addr [8];
      exp_addr = '{10, 266, 522, 778, 11, 267, 523, 779};
      bus.start    = 1'b0;
      bus.base_col = '0;
      bus.num_cols = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;

      // asynchronous reset, checked before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("reset_mem_en", 64'(bus.mem_en), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_valid", 64'(bus.feed_valid), 64'd0);
      chk("reset_feed", bus.feed_data, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // directed K=4 matrix
      mem[0] = 16'd1;   mem[1] = 16'd2;   mem[2] = 16'd3;   mem[3] = 16'd4;
      mem[257] = 16'd5; mem[258] = 16'd6; mem[259] = 16'd7;
      mem[514] = 16'd9; mem[515] = 16'd10;
      mem[771] = 16'd13;
      drive(4, 0);
      run_pass(4, 0, -5, -5, 1'b0, 0, 0);
      check_k4_directed();
      idle(2);

      // reset in cycle 12, then the same pass again
      drive(4, 0);
      run_pass(4, 0, -5, 12, 1'b0, 0, 0);
      chk("rst_pass_no_done", 64'(done_cyc), 64'hffff_ffff_ffff_ffff);
      drive(4, 0);
      run_pass(4, 0, -5, -5, 1'b0, 0, 0);
      check_k4_directed();
      idle(1);

      // K=0: immediate done, nothing else
      drive(0, 17);
      run_pass(0, 17, -5, -5, 1'b0, 0, 0);
      chk("k0_done_cycle", 64'(done_cyc), 64'd1);
      chk("k0_beats", 64'(beats_got.size()), 64'd0);
      idle(2);

      // second start during a pass is ignored
      drive(4, 0);
      run_pass(4, 0, 10, -5, 1'b0, 0, 0);
      check_k4_directed();
      idle(3);

      // address order
      fill_random();
      drive(2, 10);
      run_pass(2, 10, -5, -5, 1'b0, 0, 0);
      chk("k2_addr_count", 64'(addr_got.size()), 64'd8);
      if (addr_got.size() == 8)
         for (int i = 0; i < 8; i++) chk("k2_addr_seq", 64'(addr_got[i]), 64'(exp_addr[i]));
      idle(1);

      // column wrap inside the row
      drive(3, 254);
      run_pass(3, 254, -5, -5, 1'b0, 0, 0);
      if (addr_got.size() == 12) begin
         chk("wrap_col0", 64'(addr_got[0]), 64'd254);
         chk("wrap_col1", 64'(addr_got[4]), 64'd255);
         chk("wrap_col2", 64'(addr_got[8]), 64'd0);
         chk("wrap_row1_a", 64'(addr_got[1]), 64'd510);
         chk("wrap_row1_b", 64'(addr_got[5]), 64'd511);
         chk("wrap_row1_c", 64'(addr_got[9]), 64'd256);
      end else begin
         chk("wrap_addr_count", 64'(addr_got.size()), 64'd12);
      end
      idle(2);

      // randomized passes
      for (int t = 0; t < 6; t++) begin
         fill_random();
         rk = $urandom_range(1, 12);
         rb = $urandom_range(0, 255);
         drive(rk, rb);
         run_pass(rk, rb, -5, -5, 1'b0, 0, 0);
         chk("rand_beat_count", 64'(beats_got.size()), 64'(rk + 3));
         idle($urandom_range(1, 3));
      end

      // back-to-back: new start in the done cycle
      fill_random();
      rb  = $urandom_range(0, 255);
      rb2 = $urandom_range(0, 255);
      drive(5, rb);
      run_pass(5, rb, -5, -5, 1'b1, 3, rb2);
      run_pass(3, rb2, -5, -5, 1'b0, 0, 0);
      chk("chain_beats", 64'(beats_got.size()), 64'd6);
      idle(2);

      // full 256-column pass with wrap
      fill_random();
      rb = $urandom_range(1, 255);
      drive(256, rb);
      run_pass(256, rb, -5, -5, 1'b0, 0, 0);
      chk("k256_reads", 64'(addr_got.size()), 64'd1024);
      chk("k256_beats", 64'(beats_got.size()), 64'd259);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/operand_skew_feeder.md
OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of array rows fed (the address math below assumes 4).
REQ-002 SHALL have parameter ROW_STRIDE, default 256, words per matrix row in operand memory.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a feed pass.
REQ-006 SHALL have port base_col  input  8  first column of the pass, sampled with start.
REQ-007 SHALL have port num_cols  input  9  column count K (0..256), sampled with start.
REQ-008 SHALL have port mem_en  output  1  operand memory read enable.
REQ-009 SHALL have port mem_addr  output  10  operand memory read address (ROW_STRIDE*row + col).
REQ-010 SHALL have port mem_data  input  16  read data, valid exactly one cycle after mem_en.
REQ-011 SHALL have port feed_data  output  64  skewed beat; bits [16r+15:16r] drive array row r.
REQ-012 SHALL have port feed_valid  output  1  one-cycle strobe qualifying feed_data.
REQ-013 SHALL have port busy  output  1  high while a pass is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of a pass.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, FLUSH, FINISH.
REQ-016 SHALL leave IDLE only when start=1 at an edge. Go to FETCH if K>0, otherwise go directly to FINISH.
REQ-017 SHALL ignore start while busy=1; the sampled base_col and num_cols SHALL be held for the whole pass.
REQ-018 SHALL issue reads in FETCH, one per cycle, in order column k=0..K-1, and within each column rows r=0..3.
REQ-019 SHALL drive mem_addr = 256*r + ((base_col+k) mod 256); the column index wraps within the row and never carries into the row field.
REQ-020 SHALL number cycles n from the start edge (n=0). The read for (k,r) SHALL be issued with mem_en=1 in cycle 4k+r+1.
REQ-021 SHALL capture mem_data into a per-row column buffer one cycle after each read is issued.
REQ-022 SHALL pass each column through per-row delay chains of depth r registers, advanced once per beat.
REQ-023 SHALL emit beat b (b = 0..K+2) with feed_valid=1 in cycle 4b+5; feed_valid SHALL be 0 in all other cycles.
REQ-024 SHALL drive feed_data row r at beat b with element (row r, column b-r) if 0 <= b-r < K, and 0 otherwise.
REQ-025 SHALL enter FLUSH after the read for (K-1, 3) is issued. In FLUSH, mem_en=0 and three zero-fill beats (b=K..K+2) are emitted on the same 4-cycle cadence.
REQ-026 SHALL enter FINISH after beat K+2. FINISH lasts one cycle with done=1, then returns to IDLE.
REQ-027 SHALL drive busy=1 from cycle 1 through the cycle of beat K+2 inclusive. busy SHALL be 0 in FINISH and IDLE.
REQ-028 SHALL keep mem_en=0 outside FETCH; mem_addr is don't-care when mem_en=0.
REQ-029 SHALL hold feed_data at its last value when feed_valid=0.
REQ-030 SHALL handle K=0 as follows: no reads, no beats, done=1 in cycle 1, busy never asserted.
REQ-031 SHALL handle K=256 as follows: all 256 columns are read, and base_col+k wraps through 255 to 0.
REQ-032 SHALL accept a start arriving in the same cycle as done (FINISH) and begin a new pass, with the first read in the following cycle.

Reset
REQ-033 SHALL, while rst=1, immediately force state=IDLE, mem_en=0, feed_valid=0, busy=0, done=0, feed_data=0, and clear all column buffers and delay chains, independent of clk.
REQ-034 SHALL abort a pass in progress on reset, emitting no further beats and no done. The first edge after rst deasserts SHALL behave as IDLE.

Verification
REQ-035 SHALL cover a K=4 pass: memory rows 0..3 hold cols 0..3 = [1,2,3,4], [0,5,6,7], [0,0,9,10], [0,0,0,13]; base_col=0, start -> 7 beats at cycles 5,9,...,29.
- beat0 = (1,0,0,0)
- beat3 = (4,6,0,0)
- beat6 = (0,0,0,13)
- done pulse at cycle 30
REQ-036 SHALL cover address order: K=2, base_col=10 -> mem_addr sequence 10,266,522,778,11,267,523,779 in cycles 1..8, with mem_en=1 only in those cycles.
REQ-037 SHALL cover column wrap: K=3, base_col=254 -> column fields 254,255,0; row-1 addresses 510,511,256.
REQ-038 SHALL cover K=0: start -> done=1 in cycle 1, busy=0 and feed_valid=0 throughout; a second start during a K=4 pass is ignored (still exactly 7 beats).
REQ-039 SHALL cover reset mid-pass: rst=1 at cycle 12 of a K=4 pass -> feed_valid, busy and mem_en are 0 immediately and no done occurs. A new start after reset SHALL produce the REQ-035 sequence again.
